seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
// - Time-multiplexes NUM_DIGITS hex nibbles onto one shared 7-segment bus with per-digit anode enables.
// - Sits downstream of the counter/decoder stages and drives the board's multi-digit display directly.
// - Inserts a blanking gap between digits to prevent ghosting.
// - Snapshots inputs once per frame so a displayed frame never tears.
// PARAMETERS
// - NUM_DIGITS    4      digits scanned, legal 1..8; digit NUM_DIGITS-1 is most significant
// - PRESCALE      50000  clk cycles per digit slot, legal >= 2
// - BLANK_CYCLES  500    cycles at slot start with all anodes off, legal 0..PRESCALE-1
// PORTS
// - clk         in   1             rising-edge clock
// - rst         in   1             synchronous, active-high reset
// - enable      in   1             1 = scan runs; 0 = freeze scan and blank display
// - digits_in   in   4*NUM_DIGITS  nibble i at [4i+3:4i]
// - dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
// - seg         out  7             {a,b,c,d,e,f,g}, active-low; seg[6]=a
// - dp          out  1             decimal point, active-low
// - an          out  NUM_DIGITS    anode enables, active-low, at most one low
// - frame_start out  1             1-cycle pulse when a new snapshot is taken
// BEHAVIOUR
// - State: slot timer t (0..PRESCALE-1), digit index idx (0..NUM_DIGITS-1), snapshot regs snap_d/snap_dp.
// - Reset: t=0, idx=0, snap=0. Outputs: an all 1, seg=7'h7F, dp=1, frame_start=0.
// - enable=1 advance:
//   - t increments each cycle.
//   - At t==PRESCALE-1: t->0 and idx->idx+1, wrapping NUM_DIGITS-1 -> 0.
// - enable=0: t and idx hold; outputs blanked one cycle later; scanning resumes from the held t/idx.
// - Snapshot: when enable && t==0 && idx==0, latch digits_in/dp_in into snap.
//   - This includes the first cycle after reset release.
//   - frame_start=1 on the following cycle.
// - All outputs are registered: values at cycle k+1 are a function of t/idx/snap at cycle k.
// - Phases, per (t, idx):
//   - BLANK (t < BLANK_CYCLES): an all 1, seg=7'h7F, dp=1.
//   - SHOW (t >= BLANK_CYCLES): an[idx]=0, others 1; seg=decode(snap_d[idx]); dp=~snap_dp[idx].
// - SHOW cycles use the current snap, including the cycle in which a new snapshot is being written.
// - Decode (hex, abcdefg):
//   - 0:01 1:4F 2:12 3:06 4:4C 5:24 6:20 7:0F
//   - 8:00 9:04 A:08 b:60 C:31 d:42 E:30 F:38
// - Frame period: NUM_DIGITS*PRESCALE cycles; a digit is lit PRESCALE-BLANK_CYCLES cycles per frame.
// - Width rules:
//   - t width is $clog2(PRESCALE), minimum 1.
//   - idx width is $clog2(NUM_DIGITS), minimum 1.
//   - No other arithmetic.
// - NUM_DIGITS=1: idx is constant 0; a snapshot is taken every slot.
// - rst mid-slot: next cycle identical to post-reset state; the partial frame is discarded.
// - rst has priority over enable.
// CONFIGURATION
// - SEG7_LZ_SUPPRESS_EN defined: leading-zero suppression.
//   - Digit i (i>0) is blanked in SHOW (an stays 1, seg=7'h7F, dp=1) when snap_d[j]==0 for all j>=i and snap_dp[j]==0 for all j>=i.
//   - Digit 0 is never suppressed. Timing is unchanged.
// - Undefined: every digit is always shown during SHOW.
// TESTING (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2)
// - Reset: hold rst 3 cycles with enable=1, digits_in=16'h4321 -> an=4'hF, seg=7'h7F, dp=1, frame_start=0 throughout.
// - Scan: release rst, digits_in=16'h4321, dp_in=0.
//   - frame_start pulses every 32 cycles.
//   - Each slot shows 2 blank cycles, then 6 cycles of an=1110/seg=4F, an=1101/seg=12, an=1011/seg=06, an=0111/seg=4C in that order.
// - Tearing: change digits_in to 16'h8765 during digit 2 SHOW.
//   - Digits 2..3 still show 3, 4.
//   - The next frame shows 5,6,7,8 (seg 24,20,0F,00).
// - Enable: drop enable for 5 cycles at t=4 of digit 1.
//   - Outputs blank 1 cycle later.
//   - After re-enable, digit 1 resumes and is lit for exactly 4 more cycles.
// - Hex+dp: digits_in=16'hFEDC, dp_in=4'b0101 -> seg 31/42/30/38; dp=0 on digits 0 and 2 only.
// - SEG7_LZ_SUPPRESS_EN, dp_in=0:
//   - 16'h0012: an[3], an[2] never 0.
//   - 16'h0000: only digit 0 lit, seg=01.
//   - 16'h1000: all four digits lit.

Source files
------------

// File: rtl/seg7_scan_mux.sv
// ============================================================================
// seg7_scan_mux
// ----------------------------------------------------------------------------
// Drives NUM_DIGITS hex nibbles onto one shared 7-segment bus, one digit at a
// time, with per-digit anode enables. Each digit slot lasts PRESCALE cycles.
// The first BLANK_CYCLES cycles of a slot keep every anode off, so the segment
// pattern can settle without ghosting onto the neighbouring digit. The inputs
// are captured once per frame, at the start of digit 0's slot, so a frame
// never mixes old and new values.
//
// Optional feature (compile-time macro SEG7_LZ_SUPPRESS_EN):
//   Leading-zero suppression. A digit i > 0 stays dark during its SHOW phase
//   when it and every more significant digit hold nibble 0 with no decimal
//   point. Digit 0 is always shown. Slot timing does not change.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   enable       1 = scan runs; 0 = scan frozen and display blanked
//   digits_in    nibble i at [4i+3:4i]; digit NUM_DIGITS-1 is most significant
//   dp_in        decimal point per digit, 1 = lit
//   seg          {a,b,c,d,e,f,g}, active-low, seg[6] = a (registered)
//   dp           decimal point, active-low (registered)
//   an           anode enables, active-low, at most one low (registered)
//   frame_start  one-cycle pulse on the cycle after a snapshot is taken
// ============================================================================
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int TW = ($clog2(PRESCALE) > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = ($clog2(NUM_DIGITS) > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PRESCALE - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);

    // Hex nibble to active-low abcdefg pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0:    pat = 7'h01;
            4'h1:    pat = 7'h4F;
            4'h2:    pat = 7'h12;
            4'h3:    pat = 7'h06;
            4'h4:    pat = 7'h4C;
            4'h5:    pat = 7'h24;
            4'h6:    pat = 7'h20;
            4'h7:    pat = 7'h0F;
            4'h8:    pat = 7'h00;
            4'h9:    pat = 7'h04;
            4'hA:    pat = 7'h08;
            4'hB:    pat = 7'h60;
            4'hC:    pat = 7'h31;
            4'hD:    pat = 7'h42;
            4'hE:    pat = 7'h30;
            4'hF:    pat = 7'h38;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    logic [TW-1:0]         t_r;
    logic [IW-1:0]         idx_r;
    logic [3:0]            snap_d_r [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] snap_dp_r;

    logic                  slot_end_s;
    logic                  snap_take_s;
    logic                  in_blank_s;
    logic [NUM_DIGITS-1:0] supp_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;
    logic [6:0]            seg_nxt_s;
    logic                  dp_nxt_s;

    // Slot timing decodes shared by the state and output logic.
    always_comb begin
        slot_end_s  = (t_r == T_LAST);
        snap_take_s = enable && (t_r == '0) && (idx_r == '0);
        // Zero-extend so the compare is done at full integer width.
        in_blank_s  = ({{(32-TW){1'b0}}, t_r} < 32'(BLANK_CYCLES));
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // Walk from the most significant digit down; a digit is suppressed while
    // everything at and above it is a plain zero. Digit 0 is always shown.
    always_comb begin
        logic zeros_above;
        supp_s      = '0;
        zeros_above = 1'b1;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            zeros_above = zeros_above && (snap_d_r[j] == 4'h0) && !snap_dp_r[j];
            if (j > 0) begin
                supp_s[j] = zeros_above;
            end else begin
                supp_s[j] = 1'b0;
            end
        end
    end
`else
    // Every digit is shown during its SHOW phase.
    always_comb begin
        supp_s = '0;
    end
`endif

    // Next output values from the current timer, index and snapshot.
    always_comb begin
        an_nxt_s  = '1;
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        if (enable && !in_blank_s && !supp_s[idx_r]) begin
            an_nxt_s[idx_r] = 1'b0;
            seg_nxt_s       = hex_to_seg(snap_d_r[idx_r]);
            dp_nxt_s        = ~snap_dp_r[idx_r];
        end else begin
            an_nxt_s  = '1;
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end
    end

    // Slot timer and digit index; both hold while enable is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_r   <= '0;
            idx_r <= '0;
        end else if (enable) begin
            if (slot_end_s) begin
                t_r   <= '0;
                idx_r <= (idx_r == I_LAST) ? '0 : idx_r + IW'(1);
            end else begin
                t_r   <= t_r + TW'(1);
            end
        end else begin
            t_r   <= t_r;
            idx_r <= idx_r;
        end
    end

    // Per-frame snapshot of the digit and decimal-point inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_d_r[i] <= 4'h0;
            end
            snap_dp_r <= '0;
        end else if (snap_take_s) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                snap_d_r[i] <= digits_in[4*i +: 4];
            end
            snap_dp_r <= dp_in;
        end else begin
            snap_dp_r <= snap_dp_r;
        end
    end

    // Registered display outputs and frame marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt_s;
            seg         <= seg_nxt_s;
            dp          <= dp_nxt_s;
            frame_start <= snap_take_s;
        end
    end

endmodule
